ysyx_210544_wb_queue: RTL
=========================

// Module: ysyx_210544_wb_queue
// PURPOSE
//  Parametrised writeback stage: DEPTH-entry in-order queue between memory stage and commit/regfile.
//  Decouples memory-stage req/ack from writeback req/ack so back-to-back instructions never stall
//  while the queue is not full. Adds youngest-match forwarding of pending rd writes to decode.
// PARAMETERS
//  XLEN    64  data/pc width
//  DEPTH   2   queue entries; power of two, >=2
//  RIDX_W  5   register index width
// PORTS
//  clk                   in   1        clock
//  rst                   in   1        synchronous, active-high reset
//  i_wb_memoryed_req     in   1        memory stage offers an instruction
//  o_wb_memoryed_ack     out  1        queue accepts (= !full)
//  i_wb_pc               in   XLEN     pc
//  i_wb_inst             in   32       instruction
//  i_wb_rd               in   RIDX_W   destination reg
//  i_wb_rd_wen           in   1        rd write enable
//  i_wb_rd_wdata         in   XLEN     rd data
//  i_wb_nocmt            in   1        no-commit flag
//  i_wb_skipcmt          in   1        difftest skip flag
//  i_wb_intrNo           in   32       interrupt number (0 = none)
//  i_wb_clint_mip        in   XLEN     CLINT mip snapshot
//  o_wb_writebacked_req  out  1        head entry valid (= !empty)
//  i_wb_writebacked_ack  in   1        consumer takes head
//  o_wb_pc/inst/rd/rd_wen/rd_wdata/nocmt/skipcmt/intrNo  out  (as inputs)  head entry fields
//  o_wb_clint_mip        out  XLEN     mip of most recently accepted entry
//  i_fwd_rs_idx          in   RIDX_W   decode source reg to look up
//  o_fwd_hit             out  1        pending write to i_fwd_rs_idx exists
//  o_fwd_data            out  XLEN     data of youngest matching entry
//  o_wb_count            out  $clog2(DEPTH+1)  occupancy
// BEHAVIOUR
//  - Reset: rd_ptr=wr_ptr=count=0, all entry valid bits 0, o_wb_clint_mip=0; every output 0 except
//    o_wb_memoryed_ack=1. Reset wins over any handshake in the same cycle.
//  - Enqueue: i_wb_memoryed_req & o_wb_memoryed_ack at posedge -> entry[wr_ptr] <= all inputs,
//    wr_ptr+1 (mod DEPTH), o_wb_clint_mip <= i_wb_clint_mip.
//  - Dequeue: o_wb_writebacked_req & i_wb_writebacked_ack at posedge -> rd_ptr+1 (mod DEPTH).
//  - Both in same cycle: count unchanged; legal when full only for dequeue (ack=0 when full,
//    no same-cycle pass-through). Empty + enqueue: head visible next cycle (latency 1).
//  - Ack/req are combinational from count: ack = count!=DEPTH, req = count!=0.
//  - Head outputs are combinational from entry[rd_ptr]; all forced to 0 when empty
//    (o_wb_intrNo included, so an interrupt number is presented exactly while its entry is head).
//  - i_wb_writebacked_ack while empty: ignored, no pointer change.
//  - Forwarding: combinational scan of valid entries with rd_wen=1 and rd==i_fwd_rs_idx; youngest
//    (closest to wr_ptr-1) wins. i_fwd_rs_idx==0 never hits; o_fwd_data=0 when no hit.
//    Entry being dequeued this cycle still counts as a hit (still valid until edge).
//  - Pointers wrap modulo DEPTH; count saturates structurally (never exceeds DEPTH).
// STRUCTURE
//  - Widths via existing `BUS_64/`BUS_32/`BUS_RIDX in defines.v; add `WB_ENTRY_W macro
//    for packed entry width there.
//  - Sub-module ysyx_210544_wb_fwd_sel: DEPTH-way youngest-match priority select (pure comb).
//  - Storage: flat reg array of packed entries + per-entry valid bits; no RAM macro.
// TESTING
//  - Reset then idle: ack=1, req=0, count=0, all head outputs 0, fwd_hit=0.
//  - DEPTH=2, ack held 0, push pc 0x80000000 and 0x80000004 -> ack drops after 2nd, count=2;
//    release ack -> heads pop in order, count 2->1->0.
//  - Full + push req + pop same cycle -> only pop occurs, count 2->1, ack rises next cycle.
//  - Push rd=5 data 0x11 then rd=5 data 0x22, lookup rs=5 -> hit=1, data=0x22; rs=0 -> hit=0.
//  - Push intrNo=7 entry -> o_wb_intrNo=7 only while that entry is head, 0 after pop/empty.
//  - Continuous push/pop for 100 cycles with wrap: output stream equals input stream, no drops.

Source files
------------

// File: rtl/ysyx_210544_wb_queue_pkg.sv
// ysyx_210544_wb_queue_pkg: shared widths and packed-entry sizing for the writeback queue
package ysyx_210544_wb_queue_pkg;
  localparam int WB_XLEN = 64;
  localparam int WB_DEPTH = 2;
  localparam int WB_RIDX_W = 5;
  localparam int INST_W = 32;
  localparam int INTR_W = 32;
  function automatic int wb_entry_w(int xlen, int ridx_w);
    return 2 * xlen + INST_W + ridx_w + INTR_W + 3;
  endfunction
endpackage

// File: rtl/ysyx_210544_wb_fwd_sel.sv
// ysyx_210544_wb_fwd_sel: youngest-match priority select over queue entries, scanned oldest to youngest
module ysyx_210544_wb_fwd_sel #(
  parameter int DEPTH = 2,
  parameter int XLEN = 64
)(
  input  logic [DEPTH-1:0]           match,
  input  logic [DEPTH-1:0][XLEN-1:0] data,
  input  logic [$clog2(DEPTH)-1:0]   rd_ptr,
  output logic                       hit,
  output logic [XLEN-1:0]            fwd_data
);
  localparam int PW = $clog2(DEPTH);
  logic [PW-1:0] idx;
  always_comb begin
    hit = 1'b0;
    fwd_data = '0;
    idx = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = rd_ptr + PW'(k);
      hit = hit | match[idx];
      fwd_data = match[idx] ? data[idx] : fwd_data;
    end
  end
endmodule

// File: rtl/ysyx_210544_wb_queue.sv
// ysyx_210544_wb_queue: in-order writeback queue decoupling memory stage from commit, with rd forwarding
module ysyx_210544_wb_queue import ysyx_210544_wb_queue_pkg::*; #(
  parameter int XLEN = WB_XLEN,
  parameter int DEPTH = WB_DEPTH,
  parameter int RIDX_W = WB_RIDX_W
)(
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_wb_memoryed_req,
  output logic                         o_wb_memoryed_ack,
  input  logic [XLEN-1:0]              i_wb_pc,
  input  logic [INST_W-1:0]            i_wb_inst,
  input  logic [RIDX_W-1:0]            i_wb_rd,
  input  logic                         i_wb_rd_wen,
  input  logic [XLEN-1:0]              i_wb_rd_wdata,
  input  logic                         i_wb_nocmt,
  input  logic                         i_wb_skipcmt,
  input  logic [INTR_W-1:0]            i_wb_intrNo,
  input  logic [XLEN-1:0]              i_wb_clint_mip,
  output logic                         o_wb_writebacked_req,
  input  logic                         i_wb_writebacked_ack,
  output logic [XLEN-1:0]              o_wb_pc,
  output logic [INST_W-1:0]            o_wb_inst,
  output logic [RIDX_W-1:0]            o_wb_rd,
  output logic                         o_wb_rd_wen,
  output logic [XLEN-1:0]              o_wb_rd_wdata,
  output logic                         o_wb_nocmt,
  output logic                         o_wb_skipcmt,
  output logic [INTR_W-1:0]            o_wb_intrNo,
  output logic [XLEN-1:0]              o_wb_clint_mip,
  input  logic [RIDX_W-1:0]            i_fwd_rs_idx,
  output logic                         o_fwd_hit,
  output logic [XLEN-1:0]              o_fwd_data,
  output logic [$clog2(DEPTH+1)-1:0]   o_wb_count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int EW = wb_entry_w(XLEN, RIDX_W);
  localparam int WD_LSB = INTR_W + 2;
  localparam int WEN_BIT = WD_LSB + XLEN;
  localparam int RD_LSB = WEN_BIT + 1;
  logic [EW-1:0] ent [DEPTH];
  logic [EW-1:0] head;
  logic [DEPTH-1:0] valid, match;
  logic [DEPTH-1:0][XLEN-1:0] ent_wdata;
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic push, pop;
  assign o_wb_memoryed_ack = count != CW'(DEPTH);
  assign o_wb_writebacked_req = count != '0;
  assign push = i_wb_memoryed_req && o_wb_memoryed_ack;
  assign pop = o_wb_writebacked_req && i_wb_writebacked_ack;
  assign head = o_wb_writebacked_req ? ent[rd_ptr] : '0;
  assign {o_wb_pc, o_wb_inst, o_wb_rd, o_wb_rd_wen, o_wb_rd_wdata, o_wb_nocmt, o_wb_skipcmt, o_wb_intrNo} = head;
  assign o_wb_count = count;
  for (genvar g = 0; g < DEPTH; g++) begin : g_match
    assign ent_wdata[g] = ent[g][WD_LSB +: XLEN];
    assign match[g] = valid[g] && ent[g][WEN_BIT] && ent[g][RD_LSB +: RIDX_W] == i_fwd_rs_idx && i_fwd_rs_idx != '0;
  end
  // payload storage carries no reset; valid bits and the empty mask keep stale data invisible
  always_ff @(posedge clk) begin
    if (push) ent[wr_ptr] <= {i_wb_pc, i_wb_inst, i_wb_rd, i_wb_rd_wen, i_wb_rd_wdata, i_wb_nocmt, i_wb_skipcmt, i_wb_intrNo};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
      valid <= '0;
      o_wb_clint_mip <= '0;
    end else begin
      if (push) begin
        valid[wr_ptr] <= 1'b1;
        wr_ptr <= wr_ptr + 1'b1;
        o_wb_clint_mip <= i_wb_clint_mip;
      end
      if (pop) begin
        valid[rd_ptr] <= 1'b0;
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end
  ysyx_210544_wb_fwd_sel #(.DEPTH(DEPTH), .XLEN(XLEN)) u_fwd_sel (
    .match(match),
    .data(ent_wdata),
    .rd_ptr(rd_ptr),
    .hit(o_fwd_hit),
    .fwd_data(o_fwd_data)
  );
endmodule
